// File: rtl/fp32_pkg.sv
// Shared binary32 constants, operand classification and the multiplier stage record.
package fp32_pkg;
   localparam int          EXP_BIAS = 127;
   localparam int          EXP_MAX  = 255;
   localparam logic [31:0] QNAN     = 32'h7FC00000;
   localparam logic [31:0] POS_INF  = 32'h7F800000;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [23:0] mant;
      logic        is_zero;
      logic        is_inf;
      logic        is_nan;
      logic        is_snan;
   } fp32_t;

   typedef struct packed {
      logic        special;
      logic [31:0] spec_res;
      logic [3:0]  spec_flags;
      logic        sign;
      logic [9:0]  exp;
      logic [47:0] prod;
   } mul_stage_t;

   // Exponent field 0 covers subnormals too: they are flushed to zero here.
   function automatic fp32_t fp32_unpack(input logic [31:0] x);
      fp32_t u;
      u.sign    = x[31];
      u.exp     = x[30:23];
      u.is_zero = (x[30:23] == 8'd0);
      u.mant    = {~u.is_zero, x[22:0]};
      u.is_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
      u.is_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
      u.is_snan = u.is_nan & ~x[22];
      return u;
   endfunction
endpackage

// File: rtl/fp32_round_pack.sv
// Normalize, round-to-nearest-even and pack a 48-bit significand whose binary point
// sits below bit 46; exp is the biased exponent for that alignment.
module fp32_round_pack
   import fp32_pkg::*;
(
   input  logic              sign,
   input  logic signed [9:0] exp,
   input  logic [47:0]       mant,
   output logic [31:0]       result,
   output logic              overflow,
   output logic              underflow,
   output logic              inexact
);
   logic [47:0]       norm;
   logic signed [9:0] exp_n;
   logic signed [9:0] exp_r;
   logic              guard, rnd, sticky, rnd_up;
   logic [24:0]       sum;
   logic [22:0]       frac;

   always_comb begin
      norm   = mant[47] ? mant : {mant[46:0], 1'b0};
      exp_n  = mant[47] ? exp + 10'sd1 : exp;
      guard  = norm[23];
      rnd    = norm[22];
      sticky = |norm[21:0];
      rnd_up = guard & (rnd | sticky | norm[24]);
      sum    = {1'b0, norm[47:24]} + {24'd0, rnd_up};
      // A rounding carry leaves 1.000..., so the fraction is all zeros.
      frac   = sum[24] ? sum[23:1] : sum[22:0];
      exp_r  = sum[24] ? exp_n + 10'sd1 : exp_n;

      inexact   = guard | rnd | sticky;
      overflow  = 1'b0;
      underflow = 1'b0;
      result    = {sign, exp_r[7:0], frac};
      if (exp_r >= $signed(10'(EXP_MAX))) begin
         overflow = 1'b1;
         inexact  = 1'b1;
         result   = {sign, POS_INF[30:0]};
      end else if (exp_r <= 10'sd0) begin
         underflow = 1'b1;
         inexact   = 1'b1;
         result    = {sign, 31'd0};
      end
   end
endmodule

// File: rtl/fp_multiplier_32.sv
// Pipelined binary32 multiplier: classify and 24x24 product, optional product
// register (LATENCY=3), then round/pack into the output register.
module fp_multiplier_32
   import fp32_pkg::*;
#(
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   output logic [31:0] result,
   output logic [3:0]  flags
);
   fp32_t              ua, ub;
   mul_stage_t         s1_d, s1_q, rp_in;
   logic [LATENCY-2:0] vld_d, vld_q;
   logic [31:0]        rp_result;
   logic               rp_ovf, rp_unf, rp_inx;
   logic               out_valid_d, out_valid_q;
   logic [31:0]        result_d, result_q;
   logic [3:0]         flags_d, flags_q;

   always_comb begin
      ua            = fp32_unpack(a);
      ub            = fp32_unpack(b);
      s1_d          = '0;
      s1_d.sign     = ua.sign ^ ub.sign;
      s1_d.exp      = 10'(ua.exp) + 10'(ub.exp) - 10'(EXP_BIAS);
      s1_d.prod     = 48'(ua.mant) * 48'(ub.mant);
      s1_d.special  = 1'b1;
      if (ua.is_nan | ub.is_nan) begin
         s1_d.spec_res   = QNAN;
         s1_d.spec_flags = {ua.is_snan | ub.is_snan, 3'b000};
      end else if ((ua.is_inf & ub.is_zero) | (ub.is_inf & ua.is_zero)) begin
         s1_d.spec_res   = QNAN;
         s1_d.spec_flags = 4'b1000;
      end else if (ua.is_inf | ub.is_inf) begin
         s1_d.spec_res = {s1_d.sign, POS_INF[30:0]};
      end else if (ua.is_zero | ub.is_zero) begin
         s1_d.spec_res = {s1_d.sign, 31'd0};
      end else begin
         s1_d.special = 1'b0;
      end
      vld_d    = vld_q << 1;
      vld_d[0] = in_valid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q  <= '0;
         vld_q <= '0;
      end else begin
         s1_q  <= s1_d;
         vld_q <= vld_d;
      end
   end

   generate
      if (LATENCY == 3) begin : g_prod_reg
         mul_stage_t s2_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) s2_q <= '0;
            else     s2_q <= s1_q;
         end
         assign rp_in = s2_q;
      end else begin : g_no_prod_reg
         assign rp_in = s1_q;
      end
   endgenerate

   fp32_round_pack u_round_pack (
      .sign      (rp_in.sign),
      .exp       ($signed(rp_in.exp)),
      .mant      (rp_in.prod),
      .result    (rp_result),
      .overflow  (rp_ovf),
      .underflow (rp_unf),
      .inexact   (rp_inx)
   );

   always_comb begin
      out_valid_d = vld_q[LATENCY-2];
      result_d    = result_q;
      flags_d     = flags_q;
      if (vld_q[LATENCY-2]) begin
         if (rp_in.special) begin
            result_d = rp_in.spec_res;
            flags_d  = rp_in.spec_flags;
         end else begin
            result_d = rp_result;
            flags_d  = {1'b0, rp_ovf, rp_unf, rp_inx};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;
endmodule

// File: tb/tb_fp_multiplier_32.sv
// Self-checking bench for fp_multiplier_32 against an arithmetic reference model.
module tb_fp_multiplier_32;
   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] a, b;
   logic        out_valid;
   logic [31:0] result;
   logic [3:0]  flags;

   int checks = 0;
   int failures = 0;

   fp_multiplier_32 #(.LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
      .out_valid(out_valid), .result(result), .flags(flags)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: exact integer product, then round by quotient/remainder.
   function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
      int ex, ey, e, k, msb;
      logic s, nx, ny, ix, iy, zx, zy;
      logic [63:0] p, q, rem, half;
      s  = x[31] ^ y[31];
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      nx = (ex == 255) && (x[22:0] != 0);
      ny = (ey == 255) && (y[22:0] != 0);
      ix = (ex == 255) && (x[22:0] == 0);
      iy = (ey == 255) && (y[22:0] == 0);
      zx = (ex == 0);
      zy = (ey == 0);
      if (nx || ny) return {((nx && !x[22]) || (ny && !y[22])), 3'b000, 32'h7FC00000};
      if ((ix && zy) || (iy && zx)) return {4'b1000, 32'h7FC00000};
      if (ix || iy) return {4'b0000, s, 8'hFF, 23'd0};
      if (zx || zy) return {4'b0000, s, 31'd0};
      p = {40'd0, 1'b1, x[22:0]} * {40'd0, 1'b1, y[22:0]};
      msb = 0;
      for (int i = 0; i < 64; i++) if (p[i]) msb = i;
      k    = msb - 23;
      q    = p >> k;
      rem  = p - (q << k);
      half = 64'd1 << (k - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         k = k + 1;
      end
      e = k + ex + ey - 150;
      if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
      if (e <= 0) return {4'b0011, s, 31'd0};
      return {3'b000, (rem != 0), s, e[7:0], q[22:0]};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 11))
         0: v = 32'h00000000;
         1: v = 32'h80000000;
         2: v = {v[31], 8'hFF, 23'd0};
         3: v = {1'b0, 8'hFF, 1'b1, v[21:0]};
         4: v = {v[31], 8'hFF, 1'b0, v[21:1], 1'b1};
         5: v = {v[31], 8'h00, v[22:1], 1'b1};
         6: v = 32'h3F800000;
         7, 8, 9: v[30:23] = 8'($urandom_range(64, 190));
         default: v[30:23] = 8'($urandom_range(1, 254));
      endcase
      return v;
   endfunction

   // Drives one operation and returns what the DUT produced and after how many cycles.
   task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic [3:0] f, output int lat);
      a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = -1; r = 'x; f = 'x;
      for (int i = 1; i <= 10; i++) begin
         if (out_valid) begin
            lat = i; r = result; f = flags;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      checks += 3;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h want=00000000", result); end
      if (flags !== 4'h0) begin failures++; $display("FAIL reset_flags got=%h want=0", flags); end
   endtask

   task automatic test_directed();
      logic [31:0] va [15] = '{32'h40400000, 32'hC0400000, 32'hC0400000, 32'h00000000, 32'h80000000,
                               32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 32'h7FC00000,
                               32'h3F800001, 32'h7F800001, 32'hFF800000, 32'h00000001, 32'h80000001};
      logic [31:0] vb [15] = '{32'h40000000, 32'h40400000, 32'hC0000000, 32'h3F800000, 32'h3F800000,
                               32'h3F800000, 32'h40000000, 32'h00800000, 32'h00000000, 32'h3F800000,
                               32'h3F800001, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F800000};
      logic [31:0] vr [15] = '{32'h40C00000, 32'hC1100000, 32'h40C00000, 32'h00000000, 32'h80000000,
                               32'h7F7FFFFF, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000,
                               32'h3F800002, 32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h80000000};
      logic [3:0]  vf [15] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0101, 4'b0011, 4'b1000, 4'h0,
                               4'b0001, 4'b1000, 4'h0, 4'h0, 4'h0};
      logic [31:0] r;
      logic [3:0]  f;
      int lat;
      for (int i = 0; i < 15; i++) begin
         do_op(va[i], vb[i], r, f, lat);
         checks += 3;
         if (lat != LAT) begin failures++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, LAT); end
         if (r !== vr[i]) begin failures++; $display("FAIL dir%0d_result %h*%h got=%h want=%h", i, va[i], vb[i], r, vr[i]); end
         if (f !== vf[i]) begin failures++; $display("FAIL dir%0d_flags %h*%h got=%b want=%b", i, va[i], vb[i], f, vf[i]); end
      end
   endtask

   task automatic test_hold();
      logic [31:0] r;
      logic [3:0]  f;
      int lat;
      do_op(32'h40400000, 32'h40400000, r, f, lat);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks += 3;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_out_valid got=%b want=0", out_valid); end
         if (result !== 32'h41100000) begin failures++; $display("FAIL hold_result got=%h want=41100000", result); end
         if (flags !== 4'h0) begin failures++; $display("FAIL hold_flags got=%b want=0000", flags); end
      end
   endtask

   task automatic test_random();
      logic [31:0] x, y, r;
      logic [3:0]  f;
      logic [35:0] m;
      int lat;
      for (int i = 0; i < 300; i++) begin
         x = rand_op();
         y = rand_op();
         m = ref_mul(x, y);
         do_op(x, y, r, f, lat);
         checks += 2;
         if (r !== m[31:0]) begin failures++; $display("FAIL rand%0d_result %h*%h got=%h want=%h", i, x, y, r, m[31:0]); end
         if (f !== m[35:32]) begin failures++; $display("FAIL rand%0d_flags %h*%h got=%b want=%b", i, x, y, f, m[35:32]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] xs [5], ys [5];
      logic [35:0] ms [5];
      int j;
      for (int i = 0; i < 5; i++) begin
         xs[i] = rand_op();
         ys[i] = rand_op();
         ms[i] = ref_mul(xs[i], ys[i]);
      end
      for (int t = 0; t <= 5 + LAT; t++) begin
         if (t < 5) begin a = xs[t]; b = ys[t]; in_valid = 1'b1; end
         else in_valid = 1'b0;
         @(posedge clk); #1;
         j = t + 1 - LAT;
         checks++;
         if (j >= 0 && j < 5) begin
            if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid%0d got=%b want=1", j, out_valid); end
            checks += 2;
            if (result !== ms[j][31:0]) begin failures++; $display("FAIL b2b_result%0d got=%h want=%h", j, result, ms[j][31:0]); end
            if (flags !== ms[j][35:32]) begin failures++; $display("FAIL b2b_flags%0d got=%b want=%b", j, flags, ms[j][35:32]); end
         end else if (out_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_idle_valid t=%0d got=%b want=0", t, out_valid);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      logic [3:0]  f;
      int lat;
      for (int t = 0; t < 4; t++) begin
         a = 32'h40000000 + 32'(t << 20); b = 32'h40400000; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid got=%b want=1", out_valid); end
      #2 rst = 1'b1;
      #1;
      checks += 3;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b want=0", out_valid); end
      if (result !== 32'h0) begin failures++; $display("FAIL rstmid_result got=%h want=00000000", result); end
      if (flags !== 4'h0) begin failures++; $display("FAIL rstmid_flags got=%b want=0000", flags); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale%0d got=%b want=0", i, out_valid); end
      end
      do_op(32'hC0400000, 32'h40400000, r, f, lat);
      checks += 2;
      if (lat != LAT) begin failures++; $display("FAIL rstmid_resume_latency got=%0d want=%0d", lat, LAT); end
      if (r !== 32'hC1100000) begin failures++; $display("FAIL rstmid_resume_result got=%h want=C1100000", r); end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      test_directed();
      test_hold();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
